// File: rtl/integration_pkg.sv
// Shared AHB-Lite fabric types: transfer/burst encodings, arbiter states and
// the fabric-wide master count used to size the arbiter.
package integration_pkg;

    localparam int unsigned master_number = 9;
    localparam int unsigned size_out      = 4;
    localparam int unsigned beat_w        = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } transfer_t;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } burst_t;

    typedef enum logic [1:0] {
        ARB    = 2'b00,
        BURST  = 2'b01,
        LOCKED = 2'b10
    } arb_state_t;

    // Beats remaining after the NONSEQ; undefined-length INCR counts as 0.
    function automatic logic [beat_w-1:0] burst_beats(input burst_t b);
        logic [beat_w-1:0] n;
        case (b)
            WRAP4, INCR4:   n = beat_w'(3);
            WRAP8, INCR8:   n = beat_w'(7);
            WRAP16, INCR16: n = beat_w'(15);
            default:        n = '0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ahb_burst_tracker.sv
// Follows the current owner's burst and lock so that bus handover is only
// offered at legal AHB points; shared with the slave-side monitor.
module ahb_burst_tracker
    import integration_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  transfer_t htrans,
    input  burst_t    hburst,
    input  logic      hready,
    input  logic      hlock,
    input  logic      owner_req,
    output logic      arb_ok_c
);

    arb_state_t        state;
    arb_state_t        state_next;
    logic [beat_w-1:0] beats_left;
    logic [beat_w-1:0] beats_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB;
            beats_left <= '0;
        end else if (hready) begin
            state      <= state_next;
            beats_left <= beats_next;
        end
    end

    // IDLE outside a burst already sees 0; mid-burst it is an early termination.
    always_comb begin
        beats_next = beats_left;
        case (htrans)
            NONSEQ:  beats_next = burst_beats(hburst);
            SEQ:     if (beats_left != '0) beats_next = beats_left - beat_w'(1);
            IDLE:    beats_next = '0;
            default: beats_next = beats_left;
        endcase
    end

    always_comb begin
        state_next = state;
        if (hlock) begin
            state_next = LOCKED;
        end else begin
            case (state)
                ARB:     if (htrans == NONSEQ && burst_beats(hburst) != '0) state_next = BURST;
                BURST:   if (beats_next == '0) state_next = ARB;
                LOCKED:  if (htrans != SEQ && htrans != BUSY) state_next = ARB;
                default: state_next = ARB;
            endcase
        end
    end

    // A granted master raising HLOCK must not lose the bus on the same edge.
    always_comb begin
        arb_ok_c = 1'b0;
        if (state == ARB && !hlock) begin
            case (htrans)
                IDLE:    arb_ok_c = 1'b1;
                NONSEQ:  arb_ok_c = (hburst == SINGLE) || (hburst == INCR && !owner_req);
                SEQ:     arb_ok_c = (hburst == INCR) ? !owner_req : (beats_left <= beat_w'(1));
                default: arb_ok_c = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB-Lite arbiter: picks the next bus owner at handover points
// and tracks the owner and lock of the current address phase.
module ahb_bus_arbiter
    import integration_pkg::*;
#(
    parameter int unsigned MASTER_NUM     = master_number,
    parameter int unsigned MASTER_W       = size_out,
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [MASTER_NUM-1:0] HBUSREQ,
    input  logic [MASTER_NUM-1:0] HLOCK,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HBURST,
    input  logic                  HREADY,
    output logic [MASTER_NUM-1:0] HGRANT,
    output logic [MASTER_W-1:0]   HMASTER,
    output logic                  HMASTLOCK
);

    localparam int unsigned SUM_W = MASTER_W + 1;

    logic [MASTER_W-1:0] rr_ptr;
    logic [MASTER_W-1:0] grant_idx_c;
    logic [MASTER_W-1:0] winner_c;
    logic                found_c;
    logic                arb_ok_c;

    // base + step wrapped into 0..MASTER_NUM-1; step never exceeds MASTER_NUM.
    function automatic logic [MASTER_W-1:0] rr_index(input logic [MASTER_W-1:0] base,
                                                     input int unsigned step);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + SUM_W'(step);
        if (sum >= SUM_W'(MASTER_NUM)) sum = sum - SUM_W'(MASTER_NUM);
        return sum[MASTER_W-1:0];
    endfunction

    always_comb begin
        grant_idx_c = '0;
        for (int unsigned i = 0; i < MASTER_NUM; i++) begin
            if (HGRANT[i]) grant_idx_c = grant_idx_c | MASTER_W'(i);
        end
    end

    // Search starts just after the last winner and wraps back onto it last.
    always_comb begin
        winner_c = MASTER_W'(DEFAULT_MASTER);
        found_c  = 1'b0;
        for (int unsigned i = 1; i <= MASTER_NUM; i++) begin
            if (!found_c && HBUSREQ[rr_index(rr_ptr, i)]) begin
                winner_c = rr_index(rr_ptr, i);
                found_c  = 1'b1;
            end
        end
    end

    ahb_burst_tracker u_tracker (
        .clk       (HCLK),
        .rst       (HRESET),
        .htrans    (transfer_t'(HTRANS)),
        .hburst    (burst_t'(HBURST)),
        .hready    (HREADY),
        .hlock     (HLOCK[grant_idx_c]),
        .owner_req (HBUSREQ[HMASTER]),
        .arb_ok_c  (arb_ok_c)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            HGRANT    <= MASTER_NUM'(1) << DEFAULT_MASTER;
            HMASTER   <= MASTER_W'(DEFAULT_MASTER);
            HMASTLOCK <= 1'b0;
            rr_ptr    <= MASTER_W'(DEFAULT_MASTER);
        end else if (HREADY) begin
            HMASTER   <= grant_idx_c;
            HMASTLOCK <= HLOCK[grant_idx_c];
            if (arb_ok_c) begin
                HGRANT <= MASTER_NUM'(1) << winner_c;
                if (found_c) rr_ptr <= winner_c;
            end
        end
    end

endmodule
